// File: rtl/dma_utils_pkg.sv
// Shared DMA types: streamer request/response, read tag and AR state encoding.
package dma_utils_pkg;

  localparam int DMA_ADDR_WIDTH = 32;
  localparam int DMA_DATA_WIDTH = 32;
  localparam int DMA_STRB_WIDTH = DMA_DATA_WIDTH / 8;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  typedef struct packed {
    logic                      valid;
    logic [DMA_ADDR_WIDTH-1:0] addr;
    logic [7:0]                alen;
    logic [2:0]                size;
    logic [1:0]                burst;
    logic [DMA_STRB_WIDTH-1:0] strb;
  } s_dma_axi_req_t;

  typedef struct packed {
    logic ready;
  } s_dma_axi_resp_t;

  typedef struct packed {
    logic [DMA_ADDR_WIDTH-1:0] addr;
    logic [7:0]                alen;
    logic [DMA_STRB_WIDTH-1:0] strb;
  } s_dma_rd_tag_t;

  typedef enum logic {
    AR_IDLE,
    AR_REQ
  } dma_ar_st_t;

endpackage

// File: rtl/dma_tag_fifo.sv
// Synchronous FIFO holding one tag per accepted AR until its final R beat.
module dma_tag_fifo
  import dma_utils_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  s_dma_rd_tag_t push_data,
  input  logic          pop,
  output s_dma_rd_tag_t head,
  output logic          full,
  output logic          empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  s_dma_rd_tag_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          do_push, do_pop;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= (rd_ptr == LAST_IDX) ? '0 : rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dma_axi_rd_if.sv
// DMA read-side AXI master: issues ARs only when downstream FIFO space is reserved
// for the whole burst, forwards R beats with per-beat strobe, flags sticky errors.
//   state   | meaning
//   AR_IDLE | no AR on the bus; may accept a streamer request
//   AR_REQ  | ARVALID held with stable fields until ARREADY
module dma_axi_rd_if
  import dma_utils_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int FIFO_SPACE_W    = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  s_dma_axi_req_t            dma_axi_req_i,
  output s_dma_axi_resp_t           dma_axi_resp_o,
  input  logic                      dma_abort_i,
  input  logic                      err_clr_i,
  output logic                      ar_valid_o,
  input  logic                      ar_ready_i,
  output logic [DMA_ADDR_WIDTH-1:0] ar_addr_o,
  output logic [7:0]                ar_len_o,
  output logic [2:0]                ar_size_o,
  output logic [1:0]                ar_burst_o,
  input  logic                      r_valid_i,
  output logic                      r_ready_o,
  input  logic [DMA_DATA_WIDTH-1:0] r_data_i,
  input  logic [1:0]                r_resp_i,
  input  logic                      r_last_i,
  input  logic [FIFO_SPACE_W-1:0]   rd_fifo_space_i,
  output logic                      rd_valid_o,
  output logic [DMA_DATA_WIDTH-1:0] rd_data_o,
  output logic [DMA_STRB_WIDTH-1:0] rd_strb_o,
  output logic                      rd_err_o,
  output logic [DMA_ADDR_WIDTH-1:0] rd_err_addr_o,
  output logic                      idle_o
);

  localparam int OW = $clog2(MAX_OUTSTANDING) + 1;
  localparam int RW = FIFO_SPACE_W + 1;
  localparam int CW = (RW > 9) ? RW : 9;
  localparam logic [OW-1:0] MAX_OUT_C = OW'(MAX_OUTSTANDING);

  dma_ar_st_t                st_q;
  logic [DMA_STRB_WIDTH-1:0] ar_strb_q;
  logic [OW-1:0]             outstanding_q;
  logic [RW-1:0]             reserved_q, space_free;
  logic [8:0]                need;
  logic [7:0]                beat_q;
  logic                      abort_act_q, abort_mode;
  logic                      issue, ar_hs, beat_acc, stray, last_beat, pop, err_now;
  logic                      tag_full, tag_empty;
  s_dma_rd_tag_t             tag_in, tag_head;

  // Free space net of reservations; saturates so a shrinking FIFO never wraps.
  assign space_free = ({1'b0, rd_fifo_space_i} > reserved_q) ?
                      ({1'b0, rd_fifo_space_i} - reserved_q) : '0;
  assign need       = {1'b0, dma_axi_req_i.alen} + 9'd1;
  assign abort_mode = dma_abort_i || abort_act_q;
  assign issue      = (st_q == AR_IDLE) && dma_axi_req_i.valid && !abort_mode &&
                      (outstanding_q < MAX_OUT_C) && !tag_full &&
                      (CW'(space_free) >= CW'(need));

  assign ar_hs                = ar_valid_o && ar_ready_i;
  assign dma_axi_resp_o.ready = ar_hs;

  assign r_ready_o = !tag_empty || abort_mode;
  assign beat_acc  = r_valid_i && !tag_empty;
  assign stray     = r_valid_i && tag_empty;
  assign last_beat = (beat_q == tag_head.alen);
  // A missing RLAST on the expected final beat still retires the burst.
  assign pop       = beat_acc && (r_last_i || last_beat);
  assign err_now   = stray ||
                     (beat_acc && ((r_resp_i != AXI_RESP_OKAY) || (r_last_i != last_beat)));

  assign rd_valid_o = beat_acc && !abort_mode;
  assign rd_data_o  = r_data_i;
  assign rd_strb_o  = tag_head.strb;
  assign idle_o     = (st_q == AR_IDLE) && (outstanding_q == '0);

  assign tag_in = '{addr: ar_addr_o, alen: ar_len_o, strb: ar_strb_q};

  dma_tag_fifo #(.DEPTH(MAX_OUTSTANDING)) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (ar_hs),
    .push_data (tag_in),
    .pop       (pop),
    .head      (tag_head),
    .full      (tag_full),
    .empty     (tag_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q       <= AR_IDLE;
      ar_valid_o <= 1'b0;
      ar_addr_o  <= '0;
      ar_len_o   <= '0;
      ar_size_o  <= '0;
      ar_burst_o <= '0;
      ar_strb_q  <= '0;
    end else begin
      case (st_q)
        AR_IDLE: if (issue) begin
          st_q       <= AR_REQ;
          ar_valid_o <= 1'b1;
          ar_addr_o  <= dma_axi_req_i.addr;
          ar_len_o   <= dma_axi_req_i.alen;
          ar_size_o  <= dma_axi_req_i.size;
          ar_burst_o <= dma_axi_req_i.burst;
          ar_strb_q  <= dma_axi_req_i.strb;
        end
        AR_REQ: if (ar_ready_i) begin
          st_q       <= AR_IDLE;
          ar_valid_o <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      outstanding_q <= '0;
      reserved_q    <= '0;
      beat_q        <= '0;
      abort_act_q   <= 1'b0;
      rd_err_o      <= 1'b0;
      rd_err_addr_o <= '0;
    end else begin
      if (ar_hs && !pop)      outstanding_q <= outstanding_q + OW'(1);
      else if (pop && !ar_hs) outstanding_q <= outstanding_q - OW'(1);

      if (issue && beat_acc) reserved_q <= reserved_q + RW'(need) - RW'(1);
      else if (issue)        reserved_q <= reserved_q + RW'(need);
      else if (beat_acc && reserved_q != '0) reserved_q <= reserved_q - RW'(1);

      if (pop)           beat_q <= '0;
      else if (beat_acc) beat_q <= beat_q + 8'd1;

      if (idle_o)           abort_act_q <= 1'b0;
      else if (dma_abort_i) abort_act_q <= 1'b1;

      // A new error outranks a same-cycle clear and re-arms address capture.
      if (err_now) begin
        rd_err_o <= 1'b1;
        if (!rd_err_o || err_clr_i) rd_err_addr_o <= tag_empty ? '0 : tag_head.addr;
      end else if (err_clr_i) begin
        rd_err_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dma_axi_rd_if.sv
// Scoreboard bench for dma_axi_rd_if: expected ARs and pushed beats are queued
// by the stimulus and popped by a negedge monitor.
module tb_dma_axi_rd_if;
  import dma_utils_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  s_dma_axi_req_t  req;
  s_dma_axi_resp_t resp;
  logic            dma_abort, err_clr;
  logic            ar_valid, ar_ready;
  logic [31:0]     ar_addr;
  logic [7:0]      ar_len;
  logic [2:0]      ar_size;
  logic [1:0]      ar_burst;
  logic            r_valid, r_ready, r_last;
  logic [31:0]     r_data;
  logic [1:0]      r_resp;
  logic [5:0]      space;
  logic            rd_valid, rd_err, idle;
  logic [31:0]     rd_data, rd_err_addr;
  logic [3:0]      rd_strb;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } ar_exp_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
  } rd_exp_t;

  ar_exp_t exp_ar[$];
  rd_exp_t exp_rd[$];
  int      n_chk  = 0;
  int      n_fail = 0;

  always #5 clk = ~clk;

  dma_axi_rd_if #(.MAX_OUTSTANDING(4), .FIFO_SPACE_W(6)) dut (
    .clk             (clk),
    .rst             (rst),
    .dma_axi_req_i   (req),
    .dma_axi_resp_o  (resp),
    .dma_abort_i     (dma_abort),
    .err_clr_i       (err_clr),
    .ar_valid_o      (ar_valid),
    .ar_ready_i      (ar_ready),
    .ar_addr_o       (ar_addr),
    .ar_len_o        (ar_len),
    .ar_size_o       (ar_size),
    .ar_burst_o      (ar_burst),
    .r_valid_i       (r_valid),
    .r_ready_o       (r_ready),
    .r_data_i        (r_data),
    .r_resp_i        (r_resp),
    .r_last_i        (r_last),
    .rd_fifo_space_i (space),
    .rd_valid_o      (rd_valid),
    .rd_data_o       (rd_data),
    .rd_strb_o       (rd_strb),
    .rd_err_o        (rd_err),
    .rd_err_addr_o   (rd_err_addr),
    .idle_o          (idle)
  );

  task automatic check1(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b", nm, act, exp);
    end
  endtask

  task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check64(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every AR handshake and every downstream push must match the queues.
  initial begin
    ar_exp_t ea, ga;
    rd_exp_t er, gr;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (ar_valid && ar_ready) begin
          ga = '{ar_addr, ar_len, ar_size, ar_burst};
          if (exp_ar.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL ar_unexpected: got ar %0h expected none", ga);
          end else begin
            ea = exp_ar.pop_front();
            check64("ar_fields", 64'(ga), 64'(ea));
          end
        end
        if (rd_valid) begin
          gr = '{rd_data, rd_strb};
          if (exp_rd.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL rd_unexpected: got push %0h expected none", gr);
          end else begin
            er = exp_rd.pop_front();
            check64("rd_beat", 64'(gr), 64'(er));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [31:0] a, input logic [7:0] l, input logic [3:0] s,
                         input logic expect_ar);
    req.valid = 1'b1;
    req.addr  = a;
    req.alen  = l;
    req.size  = 3'd2;
    req.burst = 2'b01;
    req.strb  = s;
    if (expect_ar) exp_ar.push_back('{a, l, 3'd2, 2'b01});
  endtask

  // Present a request and wait for acceptance; lat is cycles from request to AR handshake.
  task automatic send_req(input logic [31:0] a, input logic [7:0] l, input logic [3:0] s,
                          input int lat);
    int n;
    n = 0;
    set_req(a, l, s, 1'b1);
    @(negedge clk);
    while (!resp.ready && n < 8) begin
      @(negedge clk);
      n++;
    end
    check32("req_latency", n, lat);
    tick();
    req.valid = 1'b0;
  endtask

  task automatic beat(input logic [31:0] d, input logic [1:0] rr, input logic l,
                      input logic fwd, input logic [3:0] s);
    r_valid = 1'b1;
    r_data  = d;
    r_resp  = rr;
    r_last  = l;
    if (fwd) exp_rd.push_back('{d, s});
    tick();
    r_valid = 1'b0;
    r_last  = 1'b0;
    r_resp  = 2'b00;
  endtask

  initial begin
    rst = 1'b0; req = '0; dma_abort = 1'b0; err_clr = 1'b0; ar_ready = 1'b0;
    r_valid = 1'b0; r_data = '0; r_resp = 2'b00; r_last = 1'b0; space = 6'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check1("rst_ar_valid", ar_valid, 1'b0);
    check1("rst_resp_ready", resp.ready, 1'b0);
    check1("rst_rd_valid", rd_valid, 1'b0);
    check1("rst_rd_err", rd_err, 1'b0);
    check32("rst_err_addr", rd_err_addr, 32'h0);
    check1("rst_idle", idle, 1'b1);
    tick();
    rst = 1'b1;
    tick();

    // Single INCR burst, 4 beats
    space = 6'd8;
    ar_ready = 1'b1;
    send_req(32'h1000, 8'd3, 4'hF, 1);
    for (int i = 0; i < 4; i++) beat(32'hA0 + i, 2'b00, (i == 3), 1'b1, 4'hF);
    @(negedge clk);
    check1("t1_idle", idle, 1'b1);
    tick();

    // Insufficient space holds the AR back
    space = 6'd2;
    set_req(32'h1100, 8'd3, 4'hF, 1'b1);
    repeat (3) tick();
    check1("t2_blocked", ar_valid, 1'b0);
    space = 6'd4;
    @(negedge clk);
    check1("t2_not_yet", ar_valid, 1'b0);
    tick();
    check1("t2_ar_issued", ar_valid, 1'b1);
    check1("t2_resp_ready", resp.ready, 1'b1);
    tick();
    req.valid = 1'b0;
    for (int i = 0; i < 4; i++) beat(32'hB0 + i, 2'b00, (i == 3), 1'b1, 4'hF);
    tick();

    // Outstanding limit: 5th request waits for one RLAST
    space = 6'd16;
    for (int i = 0; i < 4; i++) send_req(32'h3000 + 32'(4 * i), 8'd0, 4'(1 << i), 1);
    set_req(32'h3010, 8'd0, 4'hF, 1'b1);
    repeat (6) tick();
    check1("t3_fifth_blocked", ar_valid, 1'b0);
    beat(32'hD0, 2'b00, 1'b1, 1'b1, 4'h1);
    begin
      int n;
      n = 0;
      @(negedge clk);
      while (!resp.ready && n < 6) begin
        @(negedge clk);
        n++;
      end
      check1("t3_fifth_accepted", resp.ready, 1'b1);
    end
    tick();
    req.valid = 1'b0;
    beat(32'hD1, 2'b00, 1'b1, 1'b1, 4'h2);
    beat(32'hD2, 2'b00, 1'b1, 1'b1, 4'h4);
    beat(32'hD3, 2'b00, 1'b1, 1'b1, 4'h8);
    beat(32'hD4, 2'b00, 1'b1, 1'b1, 4'hF);
    @(negedge clk);
    check1("t3_idle", idle, 1'b1);
    tick();

    // Error capture, first-only address, clear
    send_req(32'h2000, 8'd3, 4'hF, 1);
    beat(32'hE0, 2'b00, 1'b0, 1'b1, 4'hF);
    beat(32'hE1, 2'b00, 1'b0, 1'b1, 4'hF);
    beat(32'hE2, 2'b10, 1'b0, 1'b1, 4'hF);
    @(negedge clk);
    check1("t4_err_set", rd_err, 1'b1);
    check32("t4_err_addr", rd_err_addr, 32'h2000);
    tick();
    beat(32'hE3, 2'b00, 1'b1, 1'b1, 4'hF);
    send_req(32'h2400, 8'd1, 4'h3, 1);
    beat(32'hE4, 2'b00, 1'b1, 1'b1, 4'h3);
    @(negedge clk);
    check32("t4_addr_kept", rd_err_addr, 32'h2000);
    check1("t4_early_last_pop", idle, 1'b1);
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    @(negedge clk);
    check1("t4_err_cleared", rd_err, 1'b0);
    tick();
    send_req(32'h2800, 8'd1, 4'hC, 1);
    beat(32'hE5, 2'b00, 1'b0, 1'b1, 4'hC);
    beat(32'hE6, 2'b00, 1'b0, 1'b1, 4'hC);
    @(negedge clk);
    check1("t4_missing_last_err", rd_err, 1'b1);
    check32("t4_missing_last_addr", rd_err_addr, 32'h2800);
    check1("t4_missing_last_pop", idle, 1'b1);
    tick();
    err_clr = 1'b1;
    beat(32'hEE, 2'b00, 1'b0, 1'b0, 4'h0);
    err_clr = 1'b0;
    @(negedge clk);
    check1("t4_stray_err_wins", rd_err, 1'b1);
    check32("t4_stray_addr", rd_err_addr, 32'h0);
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    @(negedge clk);
    check1("t4_err_cleared2", rd_err, 1'b0);
    tick();

    // Abort with AR pending: hold ARVALID, no new AR, drain silently
    ar_ready = 1'b0;
    set_req(32'h5000, 8'd1, 4'hF, 1'b1);
    tick();
    check1("t5_ar_valid", ar_valid, 1'b1);
    dma_abort = 1'b1;
    tick();
    dma_abort = 1'b0;
    repeat (2) tick();
    check1("t5_ar_held", ar_valid, 1'b1);
    check32("t5_ar_addr_stable", ar_addr, 32'h5000);
    ar_ready = 1'b1;
    @(negedge clk);
    check1("t5_resp_ready", resp.ready, 1'b1);
    tick();
    ar_ready = 1'b0;
    set_req(32'h5100, 8'd0, 4'hF, 1'b0);
    repeat (3) tick();
    check1("t5_no_new_ar", ar_valid, 1'b0);
    check1("t5_r_ready", r_ready, 1'b1);
    beat(32'hF0, 2'b00, 1'b0, 1'b0, 4'hF);
    beat(32'hF1, 2'b00, 1'b1, 1'b0, 4'hF);
    req.valid = 1'b0;
    @(negedge clk);
    check1("t5_idle", idle, 1'b1);
    tick();

    // Asynchronous reset mid-burst
    ar_ready = 1'b1;
    send_req(32'h6000, 8'd3, 4'hF, 1);
    beat(32'hC0, 2'b10, 1'b0, 1'b1, 4'hF);
    @(negedge clk);
    check1("t6_err_before", rd_err, 1'b1);
    check32("t6_err_addr_before", rd_err_addr, 32'h6000);
    tick();
    ar_ready = 1'b0;
    set_req(32'h6100, 8'd0, 4'hF, 1'b0);
    tick();
    check1("t6_ar_valid_before", ar_valid, 1'b1);
    #2;
    r_valid = 1'b1;
    r_data  = 32'hC1;
    rst     = 1'b0;
    #1;
    check1("t6_ar_valid", ar_valid, 1'b0);
    check1("t6_resp_ready", resp.ready, 1'b0);
    check1("t6_rd_valid", rd_valid, 1'b0);
    check1("t6_rd_err", rd_err, 1'b0);
    check32("t6_err_addr", rd_err_addr, 32'h0);
    check1("t6_idle", idle, 1'b1);
    r_valid   = 1'b0;
    req.valid = 1'b0;
    tick();
    rst = 1'b1;
    repeat (2) tick();

    check32("ar_queue_empty", exp_ar.size(), 32'd0);
    check32("rd_queue_empty", exp_rd.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
